// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the fetch sequencer: datapath width, FSM state encoding
// and the per-state decode of the control outputs.
package fetch_ctrl_pkg;

  localparam int CPU_WIDTH         = 32;
  localparam int FETCH_STATE_WIDTH = 3;

  typedef enum logic [FETCH_STATE_WIDTH-1:0] {
    FETCH_BOOT = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_EXEC = 3'd2,
    FETCH_HALT = 3'd3,
    FETCH_TRAP = 3'd4
  } fetch_state_e;

  typedef struct packed {
    logic req;
    logic inst_valid;
    logic pc_ena;
    logic halted;
    logic trap;
  } fetch_flags_t;

  // Each control output is high in exactly one state.
  function automatic fetch_flags_t state_flags(input fetch_state_e s);
    fetch_flags_t f;
    f            = '0;
    f.req        = (s == FETCH_REQ);
    f.inst_valid = (s == FETCH_EXEC);
    f.pc_ena     = (s == FETCH_EXEC);
    f.halted     = (s == FETCH_HALT);
    f.trap       = (s == FETCH_TRAP);
    return f;
  endfunction

  function automatic logic is_misaligned(input logic [CPU_WIDTH-1:0] pc);
    return pc[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer
// (master) and instruction memory (slave).
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic                 req;
  logic [CPU_WIDTH-1:0] addr;
  logic                 ack;
  logic [CPU_WIDTH-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches over the imem bus, holds the
// instruction for execute, and commits next_pc / halts / traps on inst_done.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst,
  fetch_ctrl_if.master         imem,
  output logic [CPU_WIDTH-1:0] inst,
  output logic                 inst_valid,
  output logic [CPU_WIDTH-1:0] curr_pc,
  output logic                 pc_ena,
  input  logic                 inst_done,
  input  logic [CPU_WIDTH-1:0] next_pc,
  input  logic                 halt_req,
  output logic                 halted,
  output logic                 trap,
  output logic [31:0]          instret
);

  fetch_state_e state;
  fetch_flags_t flags;

  assign imem.req   = flags.req;
  assign imem.addr  = curr_pc;
  assign inst_valid = flags.inst_valid;
  assign pc_ena     = flags.pc_ena;
  assign halted     = flags.halted;
  assign trap       = flags.trap;

  // Flags are loaded together with the state so they always match it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= FETCH_BOOT;
      flags   <= state_flags(FETCH_BOOT);
      curr_pc <= RESET_PC;
      inst    <= '0;
      instret <= '0;
    end else begin
      case (state)
        FETCH_BOOT: begin
          state <= FETCH_REQ;
          flags <= state_flags(FETCH_REQ);
        end
        FETCH_REQ: begin
          if (imem.ack) begin
            inst  <= imem.rdata;
            state <= FETCH_EXEC;
            flags <= state_flags(FETCH_EXEC);
          end
        end
        FETCH_EXEC: begin
          if (inst_done) begin
            // A misaligned target traps before retiring, even with halt_req.
            if (is_misaligned(next_pc)) begin
              state <= FETCH_TRAP;
              flags <= state_flags(FETCH_TRAP);
            end else begin
              curr_pc <= next_pc;
              instret <= instret + 32'd1;
              state   <= halt_req ? FETCH_HALT : FETCH_REQ;
              flags   <= state_flags(halt_req ? FETCH_HALT : FETCH_REQ);
            end
          end
        end
        FETCH_HALT: begin
          if (!halt_req) begin
            state <= FETCH_REQ;
            flags <= state_flags(FETCH_REQ);
          end
        end
        FETCH_TRAP: begin
          state <= FETCH_TRAP;
          flags <= state_flags(FETCH_TRAP);
        end
        default: begin
          state <= FETCH_BOOT;
          flags <= state_flags(FETCH_BOOT);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: reset, sequential fetch,
// delayed ack, branch, halt, trap, instret wrap and mid-fetch reset.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [CPU_WIDTH-1:0] inst;
  logic                 inst_valid;
  logic [CPU_WIDTH-1:0] curr_pc;
  logic                 pc_ena;
  logic                 inst_done;
  logic [CPU_WIDTH-1:0] next_pc;
  logic                 halt_req;
  logic                 halted;
  logic                 trap;
  logic [31:0]          instret;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_instret;

  fetch_ctrl_if imem_bus ();

  fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem       (imem_bus.master),
    .inst       (inst),
    .inst_valid (inst_valid),
    .curr_pc    (curr_pc),
    .pc_ena     (pc_ena),
    .inst_done  (inst_done),
    .next_pc    (next_pc),
    .halt_req   (halt_req),
    .halted     (halted),
    .trap       (trap),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; imem_bus.ack = 1'b0; imem_bus.rdata = '0;
    inst_done = 1'b0; next_pc = '0; halt_req = 1'b0;
    tick(); tick();
    checks++;
    if ({imem_bus.req, inst_valid, pc_ena, halted, trap} !== 5'b00000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 00000", {imem_bus.req, inst_valid, pc_ena, halted, trap});
    end
    checks++;
    if (curr_pc !== 32'h0 || inst !== 32'h0 || instret !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_regs: got pc=%h inst=%h instret=%h expected all 0", curr_pc, inst, instret);
    end
    rst = 1'b0;
    checks++;
    if (imem_bus.req !== 1'b0) begin
      errors++; $display("[TB] FAIL boot_req: got %b expected 0", imem_bus.req);
    end
    tick();
    checks++;
    if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin
      errors++; $display("[TB] FAIL first_req: got req=%b addr=%h expected 1/00000000", imem_bus.req, imem_bus.addr);
    end
    exp_instret = 32'd0;
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'(4 * i) || pc_ena !== 1'b0) begin
        errors++; $display("[TB] FAIL seq_req%0d: got req=%b addr=%h pc_ena=%b expected 1/%h/0", i, imem_bus.req, imem_bus.addr, pc_ena, 32'(4 * i));
      end
      imem_bus.ack = 1'b1; imem_bus.rdata = 32'h1000_0000 + 32'(i);
      tick();
      imem_bus.ack = 1'b0;
      checks++;
      if (inst_valid !== 1'b1 || pc_ena !== 1'b1 || imem_bus.req !== 1'b0 || inst !== 32'h1000_0000 + 32'(i)) begin
        errors++; $display("[TB] FAIL seq_exec%0d: got valid=%b ena=%b req=%b inst=%h expected 1/1/0/%h", i, inst_valid, pc_ena, imem_bus.req, inst, 32'h1000_0000 + 32'(i));
      end
      inst_done = 1'b1; next_pc = 32'(4 * (i + 1));
      tick();
      inst_done = 1'b0;
      exp_instret++;
      checks++;
      if (instret !== exp_instret) begin
        errors++; $display("[TB] FAIL seq_instret%0d: got %0d expected %0d", i, instret, exp_instret);
      end
    end
  endtask

  task automatic test_delayed_ack;
    for (int i = 0; i < 3; i++) begin
      imem_bus.rdata = 32'hDEAD_0000 + 32'(i);
      checks++;
      if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'd12 || inst !== 32'h1000_0002) begin
        errors++; $display("[TB] FAIL wait%0d: got req=%b addr=%h inst=%h expected 1/0000000c/10000002", i, imem_bus.req, imem_bus.addr, inst);
      end
      tick();
    end
    checks++;
    if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'd12 || inst_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL wait_last: got req=%b addr=%h valid=%b expected 1/0000000c/0", imem_bus.req, imem_bus.addr, inst_valid);
    end
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0000_ABCD;
    tick();
    checks++;
    if (inst !== 32'h0000_ABCD || inst_valid !== 1'b1) begin
      errors++; $display("[TB] FAIL late_capture: got inst=%h valid=%b expected 0000abcd/1", inst, inst_valid);
    end
    imem_bus.rdata = 32'h5555_5555;
    tick();
    imem_bus.ack = 1'b0;
    checks++;
    if (inst !== 32'h0000_ABCD || inst_valid !== 1'b1 || curr_pc !== 32'd12 || instret !== exp_instret) begin
      errors++; $display("[TB] FAIL exec_ack_ignored: got inst=%h valid=%b pc=%h instret=%0d expected 0000abcd/1/0000000c/%0d", inst, inst_valid, curr_pc, instret, exp_instret);
    end
  endtask

  task automatic test_branch;
    inst_done = 1'b1; next_pc = 32'h100;
    tick();
    inst_done = 1'b0;
    exp_instret++;
    checks++;
    if (imem_bus.addr !== 32'h100 || imem_bus.req !== 1'b1 || pc_ena !== 1'b0 || instret !== exp_instret) begin
      errors++; $display("[TB] FAIL branch: got addr=%h req=%b ena=%b instret=%0d expected 00000100/1/0/%0d", imem_bus.addr, imem_bus.req, pc_ena, instret, exp_instret);
    end
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0000_0100;
    tick();
    imem_bus.ack = 1'b0;
    checks++;
    if (pc_ena !== 1'b1) begin
      errors++; $display("[TB] FAIL branch_ena: got %b expected 1", pc_ena);
    end
    inst_done = 1'b1; next_pc = 32'd8;
    tick();
    inst_done = 1'b0;
    exp_instret++;
    checks++;
    if (imem_bus.addr !== 32'd8 || pc_ena !== 1'b0) begin
      errors++; $display("[TB] FAIL branch_back: got addr=%h ena=%b expected 00000008/0", imem_bus.addr, pc_ena);
    end
  endtask

  task automatic test_halt;
    halt_req = 1'b1;
    tick();
    checks++;
    if (imem_bus.req !== 1'b1 || halted !== 1'b0 || imem_bus.addr !== 32'd8) begin
      errors++; $display("[TB] FAIL halt_in_req: got req=%b halted=%b addr=%h expected 1/0/00000008", imem_bus.req, halted, imem_bus.addr);
    end
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0000_0008;
    tick();
    imem_bus.ack = 1'b0;
    checks++;
    if (inst_valid !== 1'b1 || halted !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_exec: got valid=%b halted=%b expected 1/0", inst_valid, halted);
    end
    inst_done = 1'b1; next_pc = 32'd12;
    tick();
    exp_instret++;
    checks++;
    if (halted !== 1'b1 || curr_pc !== 32'd12 || instret !== exp_instret || imem_bus.req !== 1'b0 || pc_ena !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_enter: got halted=%b pc=%h instret=%0d req=%b ena=%b expected 1/0000000c/%0d/0/0", halted, curr_pc, instret, exp_instret, imem_bus.req, pc_ena);
    end
    next_pc = 32'h40; imem_bus.ack = 1'b1;
    tick();
    checks++;
    if (halted !== 1'b1 || curr_pc !== 32'd12 || instret !== exp_instret) begin
      errors++; $display("[TB] FAIL halt_hold: got halted=%b pc=%h instret=%0d expected 1/0000000c/%0d", halted, curr_pc, instret, exp_instret);
    end
    halt_req = 1'b0; inst_done = 1'b0; imem_bus.ack = 1'b0;
    tick();
    checks++;
    if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'd12 || halted !== 1'b0) begin
      errors++; $display("[TB] FAIL halt_exit: got req=%b addr=%h halted=%b expected 1/0000000c/0", imem_bus.req, imem_bus.addr, halted);
    end
  endtask

  task automatic test_trap;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0000_0C0C;
    tick();
    imem_bus.ack = 1'b0;
    inst_done = 1'b1; next_pc = 32'h102; halt_req = 1'b1;
    tick();
    checks++;
    if (trap !== 1'b1 || halted !== 1'b0 || curr_pc !== 32'd12 || instret !== exp_instret || imem_bus.req !== 1'b0) begin
      errors++; $display("[TB] FAIL trap_enter: got trap=%b halted=%b pc=%h instret=%0d req=%b expected 1/0/0000000c/%0d/0", trap, halted, curr_pc, instret, exp_instret, imem_bus.req);
    end
    halt_req = 1'b0; next_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      imem_bus.ack = i[0];
      tick();
      checks++;
      if (trap !== 1'b1 || imem_bus.req !== 1'b0 || curr_pc !== 32'd12) begin
        errors++; $display("[TB] FAIL trap_sticky%0d: got trap=%b req=%b pc=%h expected 1/0/0000000c", i, trap, imem_bus.req, curr_pc);
      end
    end
    imem_bus.ack = 1'b0; inst_done = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_instret = 32'd0;
    checks++;
    if (trap !== 1'b0 || curr_pc !== 32'h0 || instret !== 32'h0 || imem_bus.req !== 1'b0) begin
      errors++; $display("[TB] FAIL trap_reset: got trap=%b pc=%h instret=%0d req=%b expected 0/00000000/0/0", trap, curr_pc, instret, imem_bus.req);
    end
    tick();
  endtask

  task automatic test_wrap;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0000_0001;
    tick();
    imem_bus.ack = 1'b0;
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    inst_done = 1'b1; next_pc = 32'd4;
    tick();
    inst_done = 1'b0;
    checks++;
    if (instret !== 32'h0 || imem_bus.addr !== 32'd4) begin
      errors++; $display("[TB] FAIL instret_wrap: got instret=%h addr=%h expected 00000000/00000004", instret, imem_bus.addr);
    end
  endtask

  task automatic test_reset_mid_req;
    imem_bus.ack = 1'b1; imem_bus.rdata = 32'h0000_0002;
    tick();
    imem_bus.ack = 1'b0;
    inst_done = 1'b1; next_pc = 32'd8;
    tick();
    inst_done = 1'b0;
    checks++;
    if (instret !== 32'd1 || imem_bus.req !== 1'b1 || imem_bus.addr !== 32'd8) begin
      errors++; $display("[TB] FAIL pre_reset: got instret=%0d req=%b addr=%h expected 1/1/00000008", instret, imem_bus.req, imem_bus.addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({imem_bus.req, inst_valid, pc_ena, halted, trap} !== 5'b00000 || curr_pc !== 32'h0 || inst !== 32'h0 || instret !== 32'h0) begin
      errors++; $display("[TB] FAIL mid_req_reset: got flags=%b pc=%h inst=%h instret=%0d expected 00000/0/0/0", {imem_bus.req, inst_valid, pc_ena, halted, trap}, curr_pc, inst, instret);
    end
    tick();
    checks++;
    if (imem_bus.req !== 1'b1 || imem_bus.addr !== 32'h0) begin
      errors++; $display("[TB] FAIL refetch: got req=%b addr=%h expected 1/00000000", imem_bus.req, imem_bus.addr);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_delayed_ack();
    test_branch();
    test_halt();
    test_trap();
    test_wrap();
    test_reset_mid_req();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
